// File: rtl/led_button_ctrl.sv
// Button-to-LED controller: per-channel sync, debounce, press pulse, toggle.
// LEDs follow one of four global modes (level, toggle, blink-toggle, blink-held).
module led_button_ctrl #(
  parameter int N_CH       = 4,
  parameter int DB_CYCLES  = 1250000,
  parameter int BLINK_HALF = 62500000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTN,
  input  logic [1:0]      MODE,
  output logic [N_CH-1:0] LD,
  output logic [N_CH-1:0] BTN_PRESS
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] stable_d;
  logic [N_CH-1:0] tog;
  logic [CW-1:0]   db_cnt [N_CH];
  logic [BW-1:0]   blink_cnt;
  logic            phase;

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge CLK) begin
    if (RST) begin
      stable <= '0;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign BTN_PRESS = stable & ~stable_d;

  // Edge-detect history and press-toggle bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      stable_d <= '0;
      tog      <= '0;
    end else begin
      stable_d <= stable;
      tog      <= tog ^ BTN_PRESS;
    end
  end

  // Shared free-running blink timer; phase flips on each wrap
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Registered LED drive selected by the global mode
  always_ff @(posedge CLK) begin
    if (RST) begin
      LD <= '0;
    end else begin
      unique case (MODE)
        2'b00: LD <= stable;
        2'b01: LD <= tog;
        2'b10: LD <= tog & {N_CH{phase}};
        2'b11: LD <= stable & {N_CH{phase}};
      endcase
    end
  end

endmodule
